// File: rtl/wakeupspi_cmd_seq_pkg.sv
// Shared types and SETUP_UCA/UCS command encoders for the wakeupspi command sequencer.
package wakeupspi_cmd_seq_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_UCA, ST_UCS, ST_PLAY} state_e;

   // Opcodes must track the SPI master register-interface decoder
   localparam logic [3:0] SPI_CMD_SETUP_UCA = 4'hD;
   localparam logic [3:0] SPI_CMD_SETUP_UCS = 4'hE;

   function automatic logic [31:0] enc_uca(input logic txrxn, input logic [31:0] addr);
      return {SPI_CMD_SETUP_UCA, txrxn, 27'b0} | addr;
   endfunction

   function automatic logic [31:0] enc_ucs(input logic txrxn, input logic [1:0] ds,
                                           input logic [31:0] size);
      return {SPI_CMD_SETUP_UCS, txrxn, ds, 25'b0} | size;
   endfunction

endpackage

// File: rtl/wakeupspi_cmd_seq_mem.sv
// Program store: DEPTH x 32 flop array, one write port, one combinational read port.
module wakeupspi_cmd_seq_mem #(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wakeupspi_cmd_seq.sv
// Replays a stored SPI command program over valid/ready, optionally preceded by a UCA/UCS pair.
module wakeupspi_cmd_seq
   import wakeupspi_cmd_seq_pkg::*;
#(
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned L2_AWIDTH_NOAL = 12,
   parameter int unsigned TRANS_SIZE     = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned LW = AW + 1
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      prog_we_i,
   input  logic [31:0]               prog_data_i,
   input  logic                      prog_clr_i,
   output logic [LW-1:0]             prog_len_o,
   output logic                      prog_full_o,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [7:0]                repeat_i,
   input  logic                      setup_en_i,
   input  logic                      setup_txrxn_i,
   input  logic [1:0]                setup_ds_i,
   input  logic [L2_AWIDTH_NOAL-1:0] setup_addr_i,
   input  logic [TRANS_SIZE-1:0]     setup_size_i,
   output logic [31:0]               cmd_data_o,
   output logic                      cmd_valid_o,
   input  logic                      cmd_ready_i,
   output logic                      busy_o,
   output logic                      done_o
);

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d, idx_nxt, raddr;
   logic [7:0]    pass_q, pass_d, rep_q, rep_d;
   logic [31:0]   ucs_q, ucs_d, data_q, data_d, rdata;
   logic [LW-1:0] len_q, len_d;
   logic          valid_q, valid_d, done_q, done_d;
   logic          mem_we, xfer, last, full;

   assign full    = (len_q == LW'(DEPTH));
   assign xfer    = valid_q & cmd_ready_i;
   assign last    = ((LW'(idx_q) + LW'(1)) == len_q);
   assign idx_nxt = last ? '0 : idx_q + AW'(1);
   // Read ahead: the word to present after the current transfer
   assign raddr   = (state_q == ST_PLAY) ? idx_nxt : '0;

   wakeupspi_cmd_seq_mem #(.DEPTH(DEPTH)) u_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (len_q[AW-1:0]),
      .wdata_i (prog_data_i),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      rep_d   = rep_q;
      ucs_d   = ucs_q;
      len_d   = len_q;
      valid_d = valid_q;
      data_d  = data_q;
      done_d  = 1'b0;
      mem_we  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            if (prog_clr_i) begin
               len_d = '0;
            end else if (prog_we_i && !full) begin
               mem_we = 1'b1;
               len_d  = len_q + LW'(1);
            end
            if (start_i && !abort_i) begin
               rep_d  = repeat_i;
               pass_d = '0;
               idx_d  = '0;
               ucs_d  = enc_ucs(setup_txrxn_i, setup_ds_i, 32'(setup_size_i));
               if (setup_en_i) begin
                  state_d = ST_UCA;
                  valid_d = 1'b1;
                  data_d  = enc_uca(setup_txrxn_i, 32'(setup_addr_i));
               end else if (len_q != '0) begin
                  state_d = ST_PLAY;
                  valid_d = 1'b1;
                  data_d  = rdata;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_UCA: begin
            if (xfer) begin
               state_d = ST_UCS;
               data_d  = ucs_q;
            end
         end
         ST_UCS: begin
            if (xfer) begin
               if (len_q != '0) begin
                  state_d = ST_PLAY;
                  idx_d   = '0;
                  data_d  = rdata;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (xfer) begin
               idx_d = idx_nxt;
               if (last) pass_d = pass_q + 8'd1;
               if (last && pass_q == rep_q) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  data_d = rdata;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort overrides sequencing only; programming in IDLE still proceeds
      if (abort_i) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         pass_q  <= '0;
         rep_q   <= '0;
         ucs_q   <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         rep_q   <= rep_d;
         ucs_q   <= ucs_d;
         len_q   <= len_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign prog_len_o  = len_q;
   assign prog_full_o = full;
   assign cmd_data_o  = data_q;
   assign cmd_valid_o = valid_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;

endmodule
